serial_tx_arbiter: RTL and testbench

Shares the single serial transmitter (partida_tx / pronto_serial handshake) between N_REQ byte-stream requesters, e.g. sensor-frame sender, reception echo/ack and debug.
- Round-robin arbitration at frame granularity; a grant is held until the requester's last byte is sent.
- An optional inter-byte gap is inserted between bytes.
- Sits between the sequencing control units and the tx_serial datapath.

---
 rtl/serial_tx_arbiter_pkg.sv | 25 ++
 rtl/serial_tx_arbiter_if.sv | 35 +++
 rtl/serial_tx_arbiter_rr.sv | 37 +++
 rtl/serial_tx_arbiter.sv | 171 +++++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_tx_arbiter_pkg.sv
// Shared definitions for the serial transmitter arbiter.
//   state_t      : FSM state codes, also shown on db_estado and decoded by the
//                  7-segment debug display
//   DATA_W_DEF   : default serial byte width
//   GRANT_W      : width of the granted-requester index
//   rr_after()   : requester index following g, wrapping at n
package serial_tx_arbiter_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int GRANT_W    = 2;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0000,
      ST_ARB     = 4'b0001,
      ST_START   = 4'b0010,
      ST_WAIT_TX = 4'b0011,
      ST_ACK     = 4'b0100,
      ST_GAP     = 4'b0101
   } state_t;

   function automatic logic [GRANT_W-1:0] rr_after(input logic [GRANT_W-1:0] g, input int n);
      return (int'(g) == n - 1) ? '0 : g + 1'b1;
   endfunction

endpackage

// File: rtl/serial_tx_arbiter_if.sv
// Bundle of requester and transmitter handshake signals around the arbiter.
//   req/req_data/req_last : byte-stream requesters (one bit / byte slice each)
//   ack                   : per-requester "byte sent, present next" pulse
//   partida_tx/tx_data    : start pulse and byte to the serial transmitter
//   pronto_serial         : transmitter finished pulse
//   busy/grant_id/erro/db_estado : status and debug
// Modports: master = arbiter side, slave = requesters + transmitter side.
interface serial_tx_arbiter_if
   import serial_tx_arbiter_pkg::*;
#(
   parameter int N_REQ  = 3,
   parameter int DATA_W = DATA_W_DEF
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_last;
   logic [N_REQ-1:0]        ack;
   logic                    partida_tx;
   logic [DATA_W-1:0]       tx_data;
   logic                    pronto_serial;
   logic                    busy;
   logic [GRANT_W-1:0]      grant_id;
   logic                    erro;
   logic [3:0]              db_estado;

   modport master (
      input  req, req_data, req_last, pronto_serial,
      output ack, partida_tx, tx_data, busy, grant_id, erro, db_estado
   );

   modport slave (
      output req, req_data, req_last, pronto_serial,
      input  ack, partida_tx, tx_data, busy, grant_id, erro, db_estado
   );
endinterface

// File: rtl/serial_tx_arbiter_rr.sv
// rr_arbiter_next: combinational round-robin select. Returns the first
// requester with req set, scanning upward from ptr_i and wrapping at N_REQ.
//   req_i     : request vector
//   ptr_i     : scan start (must be < N_REQ)
//   idx_o     : selected index (0 when nothing requests)
//   any_req_o : at least one request present
module rr_arbiter_next #(
   parameter int N_REQ = 3,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_req_o
);
   logic [2*N_REQ-1:0] req_dbl;
   logic [N_REQ-1:0]   req_rot;
   logic               found;

   // Rotating a doubled copy puts requester ptr_i at bit 0 of req_rot.
   assign req_dbl = {req_i, req_i};
   assign req_rot = N_REQ'(req_dbl >> ptr_i);

   always_comb begin
      idx_o = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && req_rot[k]) begin
            found = 1'b1;
            idx_o = IDX_W'((int'(ptr_i) + k) % N_REQ);
         end
      end
   end

   assign any_req_o = |req_i;

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares one serial transmitter between N_REQ byte-stream requesters with
// frame-granular round-robin; a grant is held until the frame's last byte.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous reset, active low
//   tx_if : serial_tx_arbiter_if.master (requesters, transmitter, status)
// Build option TX_TIMEOUT_EN: adds a WAIT_TX watchdog of TIMEOUT clocks that
// pulses erro and abandons the frame; otherwise erro is constant 0.
//
// state   | meaning
// IDLE    | no grant, waiting for any req
// ARB     | pick next requester from rr pointer
// START   | partida_tx pulse, latch byte and last flag
// WAIT_TX | byte in flight, wait for pronto_serial
// ACK     | ack pulse to granted requester
// GAP     | inter-byte idle clocks
module serial_tx_arbiter
   import serial_tx_arbiter_pkg::*;
#(
   parameter int N_REQ      = 3,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int GAP_CYCLES = 0,
   parameter int TIMEOUT    = 1000000
) (
   input  logic                clock,
   input  logic                reset,
   serial_tx_arbiter_if.master tx_if
);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   if (N_REQ < 2 || N_REQ > 4 || TIMEOUT < 1) begin : g_param_chk
      $error("serial_tx_arbiter: unsupported parameter set");
   end

   state_t             state_q, state_d;
   logic [GRANT_W-1:0] grant_q, grant_d, rr_q, rr_d, arb_idx;
   logic               last_q, last_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;
   logic               any_req, timeout_hit;
   logic [DATA_W-1:0]  sel_data;
   logic               sel_last, sel_req, cont_release;
   state_t             cont_state;
   logic [N_REQ-1:0]   ack_vec;

   rr_arbiter_next #(.N_REQ(N_REQ), .IDX_W(GRANT_W)) u_rr (
      .req_i     (tx_if.req),
      .ptr_i     (rr_q),
      .idx_o     (arb_idx),
      .any_req_o (any_req)
   );

`ifdef TX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                     wd_q <= '0;
      else if (state_q == ST_START)   wd_q <= '0;
      else if (state_q == ST_WAIT_TX) wd_q <= wd_q + 1'b1;
   end

   // Fires on the clock in which the counter reaches TIMEOUT; a pronto_serial
   // arriving in that same clock still wins.
   assign timeout_hit = (state_q == ST_WAIT_TX) && !tx_if.pronto_serial &&
                        (wd_q == WD_W'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // Granted requester's inputs, muxed without a variable part-select.
   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      sel_req  = 1'b0;
      ack_vec  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q == GRANT_W'(i)) begin
            sel_data   = tx_if.req_data[i*DATA_W +: DATA_W];
            sel_last   = tx_if.req_last[i];
            sel_req    = tx_if.req[i];
            ack_vec[i] = (state_q == ST_ACK);
         end
      end
   end

   // After a byte: keep the grant while the frame continues, otherwise release
   // it (completed or abandoned frame) and arbitrate again.
   assign cont_release = last_q || !sel_req;
   assign cont_state   = !cont_release ? ST_START : (any_req ? ST_ARB : ST_IDLE);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_d      = rr_q;
      last_d    = last_q;
      gap_d     = gap_q;
      tx_data_d = tx_data_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) state_d = ST_ARB;
         end
         ST_ARB: begin
            if (any_req) begin
               grant_d = arb_idx;
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            tx_data_d = sel_data;
            last_d    = sel_last;
            state_d   = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (tx_if.pronto_serial) begin
               state_d = ST_ACK;
            end else if (timeout_hit) begin
               rr_d    = rr_after(grant_q, N_REQ);
               state_d = ST_IDLE;
            end
         end
         ST_ACK: begin
            if (GAP_CYCLES > 0) begin
               gap_d   = '0;
               state_d = ST_GAP;
            end else begin
               state_d = cont_state;
               if (cont_release) rr_d = rr_after(grant_q, N_REQ);
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
               state_d = cont_state;
               if (cont_release) rr_d = rr_after(grant_q, N_REQ);
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         rr_q      <= '0;
         last_q    <= 1'b0;
         gap_q     <= '0;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_q      <= rr_d;
         last_q    <= last_d;
         gap_q     <= gap_d;
         tx_data_q <= tx_data_d;
      end
   end

   assign tx_if.ack        = ack_vec;
   assign tx_if.partida_tx = (state_q == ST_START);
   assign tx_if.tx_data    = tx_data_q;
   assign tx_if.busy       = (state_q != ST_IDLE);
   assign tx_if.grant_id   = grant_q;
   assign tx_if.erro       = timeout_hit;
   assign tx_if.db_estado  = state_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
module tb_serial_tx_arbiter;
   import serial_tx_arbiter_pkg::*;

   localparam int N      = 3;
   localparam int DW     = 8;
   localparam int GAP    = 4;
   localparam int TO     = 20;
   localparam int TX_LAT = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_tx_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

   serial_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
      .clock (clk),
      .reset (rst_n),
      .tx_if (bus)
   );

   int n_pass = 0, n_checks = 0, n_fail = 0;
   int cyc = 0;

   // Requester byte queues: {last, byte}; frame list per requester for the model.
   logic [8:0] rbuf [N][64];
   int head [N], tail [N];
   int fr_start [N][8], fr_len [N][8], nfr [N];
   int m_rr = 0;

   // Expected byte sequence from the frame-level round-robin model.
   int exp_req [$], exp_byte [$], exp_lat [$];
   int k_exp = 0;
   int ref_cyc = 0, cur_req = -1, pend_txd = -1;
   int tx_cnt = 0;
   bit tx_en = 1'b1;
   int acks = 0, erros = 0, erro_cyc = -1, part_cyc = -1;
   logic last_busy = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void clear_all();
      for (int i = 0; i < N; i++) begin
         head[i] = 0; tail[i] = 0; nfr[i] = 0;
      end
      exp_req.delete(); exp_byte.delete(); exp_lat.delete();
      k_exp = 0; cur_req = -1; pend_txd = -1;
      acks = 0; erros = 0; erro_cyc = -1; part_cyc = -1;
   endfunction

   function automatic void begin_frame(input int r);
      fr_start[r][nfr[r]] = tail[r];
      fr_len[r][nfr[r]]   = 0;
      nfr[r]++;
   endfunction

   function automatic void push_byte(input int r, input logic [7:0] b, input bit last);
      rbuf[r][tail[r]] = {last, b};
      tail[r]++;
      fr_len[r][nfr[r]-1]++;
   endfunction

   function automatic void add_rand_frame(input int r, input int len, input bit trunc);
      begin_frame(r);
      for (int b = 0; b < len; b++)
         push_byte(r, 8'($urandom_range(0, 255)), (b == len - 1) && !trunc);
   endfunction

   // Frames are served whole, requesters visited round-robin from m_rr.
   function automatic void plan();
      int fi [N];
      bit first;
      int r;
      first = 1'b1;
      for (int i = 0; i < N; i++) fi[i] = 0;
      while (1) begin
         r = -1;
         for (int j = 0; j < N; j++) begin
            int c;
            c = (m_rr + j) % N;
            if (r < 0 && fi[c] < nfr[c]) r = c;
         end
         if (r < 0) break;
         for (int b = 0; b < fr_len[r][fi[r]]; b++) begin
            exp_req.push_back(r);
            exp_byte.push_back(int'(rbuf[r][fr_start[r][fi[r]] + b][7:0]));
            exp_lat.push_back(first ? 2 : (b == 0 ? 2 + GAP : 1 + GAP));
            first = 1'b0;
         end
         fi[r]++;
         m_rr = (r + 1) % N;
      end
   endfunction

   task automatic drive_reqs();
      logic [N-1:0]    r, l;
      logic [N*DW-1:0] d;
      r = '0; l = '0; d = '0;
      for (int i = 0; i < N; i++) begin
         if (head[i] < tail[i]) begin
            r[i] = 1'b1;
            l[i] = rbuf[i][head[i]][8];
            d[i*DW +: DW] = rbuf[i][head[i]][7:0];
         end
      end
      bus.req = r; bus.req_last = l; bus.req_data = d;
   endtask

   task automatic tick();
      logic s_part, s_erro;
      logic [N-1:0] s_ack, e_ack;
      logic [1:0] s_grant;
      logic [DW-1:0] s_txd;
      logic [3:0] s_st;
      @(posedge clk);
      #1;
      cyc++;
      s_part = bus.partida_tx; s_erro = bus.erro; s_ack = bus.ack;
      s_grant = bus.grant_id; s_txd = bus.tx_data; s_st = bus.db_estado;
      last_busy = bus.busy;

      bus.pronto_serial = 1'b0;
      if (tx_cnt > 0) begin
         tx_cnt--;
         if (tx_cnt == 0) bus.pronto_serial = 1'b1;
      end

      if (pend_txd >= 0) begin
         check("tx_data", 32'(s_txd), pend_txd);
         pend_txd = -1;
      end
      if (s_part) begin
         check("partida_expected", 32'(k_exp < exp_req.size()), 1);
         if (k_exp < exp_req.size()) begin
            check("grant_id", 32'(s_grant), exp_req[k_exp]);
            check("start_state", 32'(s_st), 2);
            check("start_latency", cyc - ref_cyc, exp_lat[k_exp]);
            pend_txd = exp_byte[k_exp];
            cur_req  = exp_req[k_exp];
            k_exp++;
         end
         part_cyc = cyc;
         if (tx_en) tx_cnt = TX_LAT;
      end
      if (s_ack != '0) begin
         e_ack = (cur_req >= 0) ? N'(1 << cur_req) : '0;
         check("ack_onehot", 32'(s_ack), 32'(e_ack));
         acks++;
         ref_cyc = cyc;
         if (cur_req >= 0 && head[cur_req] < tail[cur_req]) head[cur_req]++;
         drive_reqs();
      end
      if (s_erro) begin
         erros++;
         erro_cyc = cyc;
         if (cur_req >= 0) head[cur_req] = tail[cur_req];
         drive_reqs();
      end
   endtask

   task automatic scenario(input string tag, input int exp_erro);
      int n;
      bit done;
      plan();
      drive_reqs();
      ref_cyc = cyc;
      n = 0;
      do begin
         tick();
         n++;
         done = (k_exp == exp_req.size()) && !last_busy;
      end while (!done && n < 1000);
      check({tag, "_complete"}, 32'(done), 1);
      check({tag, "_acks"}, acks, tx_en ? exp_req.size() : 0);
      check({tag, "_erro"}, erros, exp_erro);
      tick();
   endtask

   initial begin
      bus.req = '0; bus.req_data = '0; bus.req_last = '0; bus.pronto_serial = 1'b0;
      clear_all();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_partida", 32'(bus.partida_tx), 0);
      check("rst_ack", 32'(bus.ack), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_grant", 32'(bus.grant_id), 0);
      check("rst_erro", 32'(bus.erro), 0);
      check("rst_state", 32'(bus.db_estado), 0);
      check("rst_txdata", 32'(bus.tx_data), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Simultaneous 2-byte frames on 0 and 2 from rr pointer 0.
      clear_all();
      begin_frame(0); push_byte(0, 8'h10, 0); push_byte(0, 8'h11, 1);
      begin_frame(2); push_byte(2, 8'h20, 0); push_byte(2, 8'h21, 1);
      scenario("contention", 0);

      // Single 3-byte frame on requester 0.
      clear_all();
      begin_frame(0); push_byte(0, 8'h41, 0); push_byte(0, 8'h42, 0); push_byte(0, 8'h0A, 1);
      scenario("single", 0);

      // Same contention again, now from rr pointer 1: requester 2 first.
      clear_all();
      begin_frame(0); push_byte(0, 8'h30, 0); push_byte(0, 8'h31, 1);
      begin_frame(2); push_byte(2, 8'h32, 0); push_byte(2, 8'h33, 1);
      scenario("contention_rr1", 0);

      // All requesters held with 1-byte frames.
      clear_all();
      for (int r = 0; r < N; r++)
         for (int f = 0; f < 2; f++) add_rand_frame(r, 1, 1'b0);
      scenario("fairness", 0);

      // Requester 1 drops after its first byte without last.
      clear_all();
      begin_frame(1); push_byte(1, 8'h77, 0);
      begin_frame(0); push_byte(0, 8'h78, 1);
      scenario("abort", 0);

      for (int round = 0; round < 4; round++) begin
         clear_all();
         for (int r = 0; r < N; r++) begin
            if ($urandom_range(0, 2) != 0) begin
               int nf;
               nf = $urandom_range(1, 2);
               for (int f = 0; f < nf; f++)
                  add_rand_frame(r, $urandom_range(1, 3), (f == nf - 1) && ($urandom_range(0, 3) == 0));
            end
         end
         if (nfr[0] + nfr[1] + nfr[2] == 0) add_rand_frame(0, 2, 1'b0);
         scenario("random", 0);
      end

      // Reset while a byte is in flight, then a stale pronto_serial.
      clear_all();
      begin_frame(1); push_byte(1, 8'h55, 0); push_byte(1, 8'h66, 1);
      plan();
      drive_reqs();
      ref_cyc = cyc;
      for (int i = 0; i < 10 && k_exp == 0; i++) tick();
      check("rst_mid_started", k_exp, 1);
      tick();
      tick();
      check("rst_mid_busy_before", 32'(bus.busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_partida", 32'(bus.partida_tx), 0);
      check("rst_mid_busy", 32'(bus.busy), 0);
      check("rst_mid_grant", 32'(bus.grant_id), 0);
      check("rst_mid_txdata", 32'(bus.tx_data), 0);
      check("rst_mid_state", 32'(bus.db_estado), 0);
      clear_all();
      tx_cnt = 0;
      m_rr = 0;
      drive_reqs();
      bus.pronto_serial = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      bus.pronto_serial = 1'b1;
      tick();
      tick();
      check("stale_pronto_busy", 32'(bus.busy), 0);
      check("stale_pronto_state", 32'(bus.db_estado), 0);
      check("stale_pronto_acks", acks, 0);

      // Recovery after reset: rr pointer back at 0.
      clear_all();
      begin_frame(1); push_byte(1, 8'h91, 1);
      begin_frame(0); push_byte(0, 8'h90, 1);
      scenario("post_reset", 0);

`ifdef TX_TIMEOUT_EN
      clear_all();
      tx_en = 1'b0;
      begin_frame(2); push_byte(2, 8'hEE, 1);
      scenario("timeout", 1);
      check("timeout_latency", erro_cyc - part_cyc, TO);
      tx_en = 1'b1;
      clear_all();
      begin_frame(1); push_byte(1, 8'hA1, 1);
      begin_frame(0); push_byte(0, 8'hA0, 1);
      scenario("after_timeout", 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
